// File: rtl/banco_registradores_if.sv
// Dump channel between the register bank and a debug/verification consumer.
//   DumpStart  consumer -> bank  request a full state dump (honoured only while halted)
//   DumpReady  consumer -> bank  current dump word accepted
//   DumpValid  bank -> consumer  dump word valid
//   DumpIdx    bank -> consumer  index of current word (0..NREGS-1 data, NREGS = flags)
//   DumpData   bank -> consumer  dump word
//   DumpBusy   bank -> consumer  dump in progress
//   DumpDone   bank -> consumer  one-cycle pulse after the last word is accepted
// The master modport is the bank side; slave is the consumer side.
interface banco_registradores_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) ();
  localparam int AW = $clog2(NREGS);

  logic              DumpStart;
  logic              DumpReady;
  logic              DumpValid;
  logic [AW:0]       DumpIdx;
  logic [DATA_W-1:0] DumpData;
  logic              DumpBusy;
  logic              DumpDone;

  modport master (
    input  DumpStart, DumpReady,
    output DumpValid, DumpIdx, DumpData, DumpBusy, DumpDone
  );

  modport slave (
    output DumpStart, DumpReady,
    input  DumpValid, DumpIdx, DumpData, DumpBusy, DumpDone
  );
endinterface

// File: rtl/banco_registradores.sv
// nRISC register bank: NREGS x DATA_W data registers plus NBOOL one-bit flag
// registers. Each file has two combinational read ports with same-cycle
// write-to-read bypass and one write port. Data register 0 can be hard-wired
// to zero (ZERO_REG=1). While Halt is high both files are frozen and a dump
// engine can stream every data register followed by one word holding the
// flags over the valid/ready channel in `dump`.
// Ports:
//   Clock, Reset_n            clock, synchronous active-low reset
//   Halt                      freeze writes, enable dump
//   RegLido1/2 -> Dado1/2     data read ports
//   WrEn, RegEscrito, DadoEscrito            data write port
//   BoolLido1/2 -> DadoBool1/2               flag read ports
//   BoolWrEn, BoolEscrito, DadoBoolEscrito   flag write port
//   dump                      dump channel (master side)
module banco_registradores #(
  parameter int DATA_W   = 8,
  parameter int NREGS    = 8,
  parameter int NBOOL    = 4,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS),
  localparam int BW = $clog2(NBOOL)
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Halt,
  input  logic [AW-1:0]          RegLido1,
  input  logic [AW-1:0]          RegLido2,
  output logic [DATA_W-1:0]      Dado1,
  output logic [DATA_W-1:0]      Dado2,
  input  logic                   WrEn,
  input  logic [AW-1:0]          RegEscrito,
  input  logic [DATA_W-1:0]      DadoEscrito,
  input  logic [BW-1:0]          BoolLido1,
  input  logic [BW-1:0]          BoolLido2,
  output logic                   DadoBool1,
  output logic                   DadoBool2,
  input  logic                   BoolWrEn,
  input  logic [BW-1:0]          BoolEscrito,
  input  logic                   DadoBoolEscrito,
  banco_registradores_if.master  dump
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS);

  logic [DATA_W-1:0] banco [NREGS];
  logic [NBOOL-1:0]  flags;

  state_t      state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic        done_q, done_d;

  logic wr_ok;
  logic bool_wr_ok;

  // A write to the hard-wired zero register is dropped entirely, so it must
  // never feed the bypass either.
  assign wr_ok      = WrEn && !Halt && !((ZERO_REG != 0) && (RegEscrito == '0));
  assign bool_wr_ok = BoolWrEn && !Halt;

  function automatic logic [DATA_W-1:0] rd_data(input logic [AW-1:0] a, input logic byp);
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    else if (byp)                     return DadoEscrito;
    else                              return banco[a];
  endfunction

  function automatic logic rd_bool(input logic [BW-1:0] a);
    if (bool_wr_ok && (BoolEscrito == a)) return DadoBoolEscrito;
    else                                  return flags[a];
  endfunction

  // Storage
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) banco[i] <= '0;
      flags <= '0;
    end else begin
      if (wr_ok)      banco[RegEscrito]  <= DadoEscrito;
      if (bool_wr_ok) flags[BoolEscrito] <= DadoBoolEscrito;
    end
  end

  // Combinational read ports
  always_comb begin
    Dado1     = rd_data(RegLido1, wr_ok && (RegEscrito == RegLido1));
    Dado2     = rd_data(RegLido2, wr_ok && (RegEscrito == RegLido2));
    DadoBool1 = rd_bool(BoolLido1);
    DadoBool2 = rd_bool(BoolLido2);
  end

  // Dump FSM: state register
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Dump FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump.DumpStart && Halt) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        // Losing Halt means the core may write again, so the snapshot is
        // no longer coherent: drop it without signalling completion.
        if (!Halt) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (dump.DumpReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Dump outputs; files are frozen while sending, so no bypass applies.
  always_comb begin
    dump.DumpValid = (state_q == SEND);
    dump.DumpBusy  = (state_q == SEND);
    dump.DumpDone  = done_q;
    dump.DumpIdx   = idx_q;
    dump.DumpData  = '0;
    if (state_q == SEND) begin
      if (!idx_q[AW]) dump.DumpData = rd_data(idx_q[AW-1:0], 1'b0);
      else            dump.DumpData = DATA_W'(flags);
    end
  end

endmodule

// File: tb/tb_banco_registradores.sv
module tb_banco_registradores;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int NBOOL  = 4;
  localparam int AW     = 3;
  localparam int BW     = 2;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Halt;
  logic [AW-1:0]     RegLido1, RegLido2;
  logic [DATA_W-1:0] Dado1, Dado2;
  logic              WrEn;
  logic [AW-1:0]     RegEscrito;
  logic [DATA_W-1:0] DadoEscrito;
  logic [BW-1:0]     BoolLido1, BoolLido2;
  logic              DadoBool1, DadoBool2;
  logic              BoolWrEn;
  logic [BW-1:0]     BoolEscrito;
  logic              DadoBoolEscrito;

  int tests = 0;
  int fails = 0;

  banco_registradores_if #(.DATA_W(DATA_W), .NREGS(NREGS)) dif ();

  banco_registradores #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NBOOL(NBOOL), .ZERO_REG(1)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Halt(Halt),
    .RegLido1(RegLido1), .RegLido2(RegLido2), .Dado1(Dado1), .Dado2(Dado2),
    .WrEn(WrEn), .RegEscrito(RegEscrito), .DadoEscrito(DadoEscrito),
    .BoolLido1(BoolLido1), .BoolLido2(BoolLido2),
    .DadoBool1(DadoBool1), .DadoBool2(DadoBool2),
    .BoolWrEn(BoolWrEn), .BoolEscrito(BoolEscrito), .DadoBoolEscrito(DadoBoolEscrito),
    .dump(dif)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] dump_exp [9];
  logic [3:0] flag_pat;

  initial begin
    dump_exp = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    flag_pat = 4'b1010;
    Reset_n = 1'b0; Halt = 1'b0;
    RegLido1 = '0; RegLido2 = '0; WrEn = 1'b0; RegEscrito = '0; DadoEscrito = '0;
    BoolLido1 = '0; BoolLido2 = '0; BoolWrEn = 1'b0; BoolEscrito = '0; DadoBoolEscrito = 1'b0;
    dif.DumpStart = 1'b0; dif.DumpReady = 1'b0;
    tick(); tick();
    Reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < NREGS; a++) begin
      RegLido1 = AW'(a); RegLido2 = AW'(NREGS - 1 - a);
      #1;
      chk("rst_dado1", 32'(Dado1), 32'h0);
      chk("rst_dado2", 32'(Dado2), 32'h0);
    end
    for (int a = 0; a < NBOOL; a++) begin
      BoolLido1 = BW'(a); BoolLido2 = BW'(NBOOL - 1 - a);
      #1;
      chk("rst_bool1", 32'(DadoBool1), 32'h0);
      chk("rst_bool2", 32'(DadoBool2), 32'h0);
    end
    chk("rst_valid", 32'(dif.DumpValid), 32'h0);
    chk("rst_busy",  32'(dif.DumpBusy),  32'h0);
    chk("rst_done",  32'(dif.DumpDone),  32'h0);
    chk("rst_idx",   32'(dif.DumpIdx),   32'h0);
    chk("rst_data",  32'(dif.DumpData),  32'h0);

    // Plain write then read
    WrEn = 1'b1; RegEscrito = 3'd3; DadoEscrito = 8'hA5;
    tick();
    WrEn = 1'b0; RegLido1 = 3'd3; #1;
    chk("wr_r3", 32'(Dado1), 32'hA5);

    // Bypass on port 1, stored value on port 2
    WrEn = 1'b1; RegEscrito = 3'd5; DadoEscrito = 8'h3C; RegLido1 = 3'd5; RegLido2 = 3'd3; #1;
    chk("byp_dado1", 32'(Dado1), 32'h3C);
    chk("byp_dado2", 32'(Dado2), 32'hA5);
    tick();
    WrEn = 1'b0; #1;
    chk("stored_r5", 32'(Dado1), 32'h3C);

    // Zero register: write discarded, no bypass
    WrEn = 1'b1; RegEscrito = 3'd0; DadoEscrito = 8'hFF; RegLido1 = 3'd0; RegLido2 = 3'd0; #1;
    chk("r0_same1", 32'(Dado1), 32'h00);
    chk("r0_same2", 32'(Dado2), 32'h00);
    tick();
    WrEn = 1'b0; #1;
    chk("r0_next", 32'(Dado1), 32'h00);

    // Boolean write with bypass
    BoolWrEn = 1'b1; BoolEscrito = 2'd2; DadoBoolEscrito = 1'b1; BoolLido1 = 2'd2; BoolLido2 = 2'd1; #1;
    chk("bbyp_1", 32'(DadoBool1), 32'h1);
    chk("bbyp_2", 32'(DadoBool2), 32'h0);
    tick();
    BoolWrEn = 1'b0; #1;
    chk("bstored", 32'(DadoBool1), 32'h1);

    // Halt freezes both files and suppresses bypass
    WrEn = 1'b1; RegEscrito = 3'd2; DadoEscrito = 8'h11;
    tick();
    Halt = 1'b1; WrEn = 1'b1; RegEscrito = 3'd2; DadoEscrito = 8'h77; RegLido1 = 3'd2;
    BoolWrEn = 1'b1; BoolEscrito = 2'd2; DadoBoolEscrito = 1'b0; BoolLido1 = 2'd2; #1;
    chk("halt_nobyp", 32'(Dado1), 32'h11);
    chk("halt_bnobyp", 32'(DadoBool1), 32'h1);
    tick();
    WrEn = 1'b0; BoolWrEn = 1'b0; Halt = 1'b0; #1;
    chk("halt_kept", 32'(Dado1), 32'h11);
    chk("halt_bkept", 32'(DadoBool1), 32'h1);

    // Load r_i = i+1 and flags = 1010 with simultaneous writes
    for (int i = 0; i < NREGS; i++) begin
      WrEn = 1'b1; RegEscrito = AW'(i); DadoEscrito = DATA_W'(i + 1);
      BoolWrEn = (i < NBOOL); BoolEscrito = BW'(i); DadoBoolEscrito = flag_pat[i % 4];
      tick();
    end
    WrEn = 1'b0; BoolWrEn = 1'b0; RegLido1 = 3'd7; RegLido2 = 3'd0; BoolLido1 = 2'd3; BoolLido2 = 2'd2; #1;
    chk("load_r7", 32'(Dado1), 32'h08);
    chk("load_r0", 32'(Dado2), 32'h00);
    chk("load_f3", 32'(DadoBool1), 32'h1);
    chk("load_f2", 32'(DadoBool2), 32'h0);

    // DumpStart ignored while not halted
    dif.DumpStart = 1'b1; dif.DumpReady = 1'b1;
    tick();
    dif.DumpStart = 1'b0; #1;
    chk("nohalt_valid", 32'(dif.DumpValid), 32'h0);
    chk("nohalt_busy",  32'(dif.DumpBusy),  32'h0);

    // Full dump with DumpReady held high
    Halt = 1'b1; dif.DumpStart = 1'b1;
    tick();
    dif.DumpStart = 1'b0;
    chk("d_busy", 32'(dif.DumpBusy), 32'h1);
    for (int k = 0; k <= NREGS; k++) begin
      #1;
      chk("d_valid", 32'(dif.DumpValid), 32'h1);
      chk("d_idx",   32'(dif.DumpIdx),   32'(k));
      chk("d_data",  32'(dif.DumpData),  32'(dump_exp[k]));
      chk("d_nodone", 32'(dif.DumpDone), 32'h0);
      tick();
    end
    chk("d_done",    32'(dif.DumpDone),  32'h1);
    chk("d_validlo", 32'(dif.DumpValid), 32'h0);
    chk("d_busylo",  32'(dif.DumpBusy),  32'h0);
    tick();
    chk("d_donepulse", 32'(dif.DumpDone), 32'h0);

    // Backpressure at index 2, then Halt drop at index 4
    dif.DumpStart = 1'b1;
    tick();
    dif.DumpStart = 1'b0;
    tick(); tick();
    dif.DumpReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_idx",  32'(dif.DumpIdx),  32'h2);
      chk("bp_data", 32'(dif.DumpData), 32'h03);
      chk("bp_valid", 32'(dif.DumpValid), 32'h1);
      tick();
    end
    chk("bp_idx_end", 32'(dif.DumpIdx), 32'h2);
    dif.DumpReady = 1'b1;
    tick();
    chk("bp_resume", 32'(dif.DumpData), 32'h04);
    tick();
    chk("ab_idx4", 32'(dif.DumpIdx), 32'h4);
    Halt = 1'b0;
    tick();
    chk("ab_valid", 32'(dif.DumpValid), 32'h0);
    chk("ab_busy",  32'(dif.DumpBusy),  32'h0);
    chk("ab_done",  32'(dif.DumpDone),  32'h0);
    tick();
    chk("ab_done2", 32'(dif.DumpDone), 32'h0);

    // Reset mid-dump at index 4
    Halt = 1'b1; dif.DumpStart = 1'b1;
    tick();
    dif.DumpStart = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rab_idx4", 32'(dif.DumpIdx), 32'h4);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("rab_valid", 32'(dif.DumpValid), 32'h0);
    chk("rab_busy",  32'(dif.DumpBusy),  32'h0);
    chk("rab_done",  32'(dif.DumpDone),  32'h0);
    chk("rab_idx",   32'(dif.DumpIdx),   32'h0);
    Halt = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      RegLido1 = AW'(a); RegLido2 = AW'(a); #1;
      chk("rab_dado1", 32'(Dado1), 32'h0);
      chk("rab_dado2", 32'(Dado2), 32'h0);
    end
    for (int a = 0; a < NBOOL; a++) begin
      BoolLido1 = BW'(a); BoolLido2 = BW'(a); #1;
      chk("rab_bool1", 32'(DadoBool1), 32'h0);
      chk("rab_bool2", 32'(DadoBool2), 32'h0);
    end
    tick();
    chk("rab_done2", 32'(dif.DumpDone), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
